// File: rtl/countdown_ctrl.sv
// Control stage for the BCD countdown digit chain: keypad entry, chain load, count tick, run/pause/done sequencing.
// Optional alarm output and auto-return from DONE are built when TIMER_ALARM_EN is defined.
module countdown_ctrl #(
  parameter int NDIGITS      = 4,
  parameter int TICK_DIV     = 100,
  parameter int ALARM_CYCLES = 50
) (
  input  logic                   clock,
  input  logic                   clrn,
  input  logic                   key_valid,
  input  logic [3:0]             key_digit,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   zero_all,
  output logic [4*NDIGITS-1:0]   load_data,
  output logic                   loadn,
  output logic                   enable,
  output logic                   running,
  output logic                   paused,
  output logic                   done
`ifdef TIMER_ALARM_EN
  ,
  output logic                   alarm
`endif
);

  localparam int EW = 4 * NDIGITS;
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  if (NDIGITS < 1 || TICK_DIV < 2 || ALARM_CYCLES < 1) begin : g_param_check
    $error("countdown_ctrl: NDIGITS>=1, TICK_DIV>=2, ALARM_CYCLES>=1 required");
  end

  logic [2:0]    state, state_n;
  logic [EW-1:0] entry, entry_n;
  logic [PW-1:0] presc, presc_n, presc_inc;
  logic          loadn_n;

`ifdef TIMER_ALARM_EN
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  logic [AW-1:0] alarm_left, alarm_left_n;
`endif

  assign presc_inc = (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;

  always_comb begin
    state_n = state;
    entry_n = entry;
    presc_n = presc;
`ifdef TIMER_ALARM_EN
    alarm_left_n = alarm_left;
`endif
    if (clear) begin
      state_n = IDLE;
      entry_n = '0;
    end else begin
      case (state)
        IDLE: begin
          // stop outranks start and key entry even though it has no effect here
          if (stop) begin
            state_n = IDLE;
          end else if (start) begin
            if (entry != '0) state_n = LOAD;
          end else if (key_valid && key_digit <= 4'd9) begin
            entry_n = (entry << 4) | EW'(key_digit);
          end
        end
        LOAD: begin
          state_n = RUN;
          presc_n = '0;
        end
        RUN: begin
          if (zero_all) begin
            state_n = DONE;
`ifdef TIMER_ALARM_EN
            alarm_left_n = AW'(ALARM_CYCLES - 1);
`endif
          end else begin
            // the cycle that sees stop still counts, so the count resumes after it
            presc_n = presc_inc;
            if (stop) state_n = PAUSE;
          end
        end
        PAUSE: begin
          if (stop)       state_n = IDLE;
          else if (start) state_n = RUN;
        end
        DONE: begin
          if (start || stop) begin
            state_n = IDLE;
`ifdef TIMER_ALARM_EN
          end else if (alarm_left == '0) begin
            state_n = IDLE;
          end else begin
            alarm_left_n = alarm_left - 1'b1;
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign loadn_n = !(clear || state_n == LOAD);

  // outputs are registered copies of what the next state implies
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      entry     <= '0;
      presc     <= '0;
      load_data <= '0;
      loadn     <= 1'b1;
      enable    <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_n;
      entry   <= entry_n;
      presc   <= presc_n;
      loadn   <= loadn_n;
      if (!loadn_n) load_data <= entry_n;
      enable  <= (state_n == RUN) && (presc_n == PW'(TICK_DIV - 1));
      running <= (state_n == RUN);
      paused  <= (state_n == PAUSE);
      done    <= (state_n == DONE);
    end
  end

`ifdef TIMER_ALARM_EN
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      alarm_left <= '0;
      alarm      <= 1'b0;
    end else begin
      alarm_left <= alarm_left_n;
      alarm      <= (state_n == DONE);
    end
  end
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: decimal-entry/run-count model compared every cycle plus directed literal checks.
module tb_countdown_ctrl;
  localparam int NDIG = 2;
  localparam int TDIV = 4;
  localparam int ACYC = 3;

  logic clock = 1'b0;
  logic clrn = 1'b0;
  logic key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic zero_all = 1'b0;
  logic [4*NDIG-1:0] load_data;
  logic loadn, enable, running, paused, done;
`ifdef TIMER_ALARM_EN
  logic alarm;
`endif

  int tests = 0;
  int fails = 0;

  countdown_ctrl #(.NDIGITS(NDIG), .TICK_DIV(TDIV), .ALARM_CYCLES(ACYC)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .zero_all(zero_all),
    .load_data(load_data), .loadn(loadn), .enable(enable),
    .running(running), .paused(paused), .done(done)
`ifdef TIMER_ALARM_EN
    , .alarm(alarm)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entry kept as a decimal number, time as the count of RUN cycles since load
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_entry = 0;
  int    m_runs = 0;
  int    m_aleft = 0;
  bit    m_clr = 1'b0;

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_mode = M_IDLE; m_entry = 0; m_runs = 0; m_aleft = 0; m_clr = 1'b0;
    end else begin
      m_clr = 1'b0;
      if (clear) begin
        m_mode = M_IDLE; m_entry = 0; m_clr = 1'b1;
      end else begin
        case (m_mode)
          M_IDLE:
            if (!stop) begin
              if (start) begin
                if (m_entry != 0) m_mode = M_LOAD;
              end else if (key_valid && key_digit < 10) begin
                m_entry = (m_entry * 10 + int'(key_digit)) % (10 ** NDIG);
              end
            end
          M_LOAD: begin m_mode = M_RUN; m_runs = 1; end
          M_RUN:
            if (zero_all) begin m_mode = M_DONE; m_aleft = ACYC; end
            else if (stop) m_mode = M_PAUSE;
            else m_runs++;
          M_PAUSE:
            if (stop) m_mode = M_IDLE;
            else if (start) begin m_mode = M_RUN; m_runs++; end
          M_DONE:
            if (start || stop) m_mode = M_IDLE;
`ifdef TIMER_ALARM_EN
            else begin
              m_aleft--;
              if (m_aleft == 0) m_mode = M_IDLE;
            end
`endif
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (clrn) begin
      check("m_loadn", 32'(loadn), 32'(!(m_mode == M_LOAD || m_clr)));
      if (m_mode == M_LOAD || m_clr)
        check("m_load_data", 32'(load_data), 32'(m_clr ? '0 : to_bcd(m_entry)));
      check("m_enable", 32'(enable), 32'(m_mode == M_RUN && (m_runs % TDIV) == 0));
      check("m_running", 32'(running), 32'(m_mode == M_RUN));
      check("m_paused", 32'(paused), 32'(m_mode == M_PAUSE));
      check("m_done", 32'(done), 32'(m_mode == M_DONE));
`ifdef TIMER_ALARM_EN
      check("m_alarm", 32'(alarm), 32'(m_mode == M_DONE));
`endif
      check("m_excl", 32'(!loadn && enable), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_loadn", 32'(loadn), 32'(1));
    check("rst_data", 32'(load_data), 32'(0));
    check("rst_enable", 32'(enable), 32'(0));
    check("rst_running", 32'(running), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    clrn = 1'b1;
    tick();

    // Keys 1,2 then start: load 12, first tick on 4th RUN cycle
    key(4'd1); key(4'd2);
    pulse_start();
    check("t2_loadn", 32'(loadn), 32'(0));
    check("t2_data", 32'(load_data), 32'h12);
    tick();
    check("t2_run1", 32'(running), 32'(1));
    tick(); tick();
    check("t2_run3_en", 32'(enable), 32'(0));
    tick();
    check("t2_run4_en", 32'(enable), 32'(1));

    // Pause in the 2nd cycle of a period, resume: tick after the remaining 2 RUN cycles
    tick(); tick();
    pulse_stop();
    check("t4_paused", 32'(paused), 32'(1));
    check("t4_pause_en", 32'(enable), 32'(0));
    tick(); tick(); tick();
    check("t4_hold_en", 32'(enable), 32'(0));
    pulse_start();
    check("t4_resume", 32'(running), 32'(1));
    check("t4_resume_en", 32'(enable), 32'(0));
    tick();
    check("t4_next_en", 32'(enable), 32'(1));

    // Expiry
    tick();
    zero_all = 1'b1;
    tick();
    check("t5_done", 32'(done), 32'(1));
    check("t5_en", 32'(enable), 32'(0));
`ifdef TIMER_ALARM_EN
    check("t5_alarm1", 32'(alarm), 32'(1));
    tick(); tick();
    check("t5_alarm3", 32'(alarm), 32'(1));
    tick();
    check("t5_alarm_end", 32'(alarm), 32'(0));
    check("t5_done_end", 32'(done), 32'(0));
`else
    tick(); tick();
    check("t5_hold", 32'(done), 32'(1));
    check("t5_hold_en", 32'(enable), 32'(0));
    pulse_stop();
    check("t5_idle", 32'(done), 32'(0));
`endif
    zero_all = 1'b0;
    tick();

    // Entry retained (12): 3 -> 23, A ignored, 4 -> 34, 5 -> 45
    key(4'd3); key(4'hA); key(4'd4); key(4'd5);
    pulse_start();
    check("t3_loadn", 32'(loadn), 32'(0));
    check("t3_data", 32'(load_data), 32'h45);
    tick();

    // clear beats stop and start in the same RUN cycle
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    check("t6_loadn", 32'(loadn), 32'(0));
    check("t6_data", 32'(load_data), 32'(0));
    check("t6_running", 32'(running), 32'(0));
    tick();
    check("t6_once", 32'(loadn), 32'(1));
    pulse_start();
    check("t3_zero_start", 32'(loadn), 32'(1));
    check("t3_zero_idle", 32'(running), 32'(0));
    key(4'd7);
    pulse_start();
    check("t6_entry07", 32'(load_data), 32'h07);
    tick(); tick(); tick();

    // Asynchronous reset in the middle of RUN
    #2 clrn = 1'b0;
    #1;
    check("t1_loadn", 32'(loadn), 32'(1));
    check("t1_data", 32'(load_data), 32'(0));
    check("t1_enable", 32'(enable), 32'(0));
    check("t1_running", 32'(running), 32'(0));
    check("t1_paused", 32'(paused), 32'(0));
    check("t1_done", 32'(done), 32'(0));
    @(negedge clock);
    #1 clrn = 1'b1;
    tick();
    pulse_start();
    check("t1_entry0", 32'(loadn), 32'(1));

    // PAUSE -> stop -> IDLE keeps the entry
    key(4'd8); key(4'd3);
    pulse_start();
    tick();
    pulse_stop();
    pulse_stop();
    check("ps_idle", 32'(paused), 32'(0));
    pulse_start();
    check("ps_reload", 32'(load_data), 32'h83);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
